// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates jump, multi-cycle, load-use and bus-hold
// requests into per-stage hold flags and a PC redirect, with a multi-cycle watchdog.
module pipe_ctrl #(
    parameter int unsigned MC_TIMEOUT  = 64,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_flag_i,
    input  logic [31:0]            jump_addr_i,
    input  logic                   mc_start_i,
    input  logic                   mc_done_i,
    input  logic                   ld_hazard_i,
    input  logic                   ext_hold_i,
    output logic                   hold_pc_o,
    output logic                   hold_if_id_o,
    output logic                   hold_id_ex_o,
    output logic                   jump_flag_o,
    output logic [31:0]            jump_addr_o,
    output logic                   misalign_o,
    output logic                   mc_timeout_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic [1:0]             state_o
);

    localparam int unsigned WdW = $clog2(MC_TIMEOUT);
    localparam logic [WdW-1:0] WdLast = WdW'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMcWait   = 2'd1,
        StRedirect = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WdW-1:0]         wd_q, wd_d;
    logic [STALL_CNT_W-1:0] stall_q;

    logic hpc, hif, hie, jmp, tmo;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        hpc     = 1'b0;
        hif     = 1'b0;
        hie     = 1'b0;
        jmp     = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            StMcWait: begin
                wd_d = wd_q + 1'b1;
                if (mc_done_i) begin
                    // Done releases the pipe; a simultaneous jump is handled as in RUN
                    if (jump_flag_i) begin
                        jmp     = 1'b1;
                        hif     = 1'b1;
                        hie     = 1'b1;
                        state_d = StRedirect;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    hpc = 1'b1;
                    hif = 1'b1;
                    hie = 1'b1;
                    if (wd_q == WdLast) begin
                        tmo     = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StRedirect: begin
                // Squash the stale word fetched before the redirect landed
                hif     = 1'b1;
                hpc     = ext_hold_i;
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
                if (jump_flag_i) begin
                    jmp     = 1'b1;
                    hif     = 1'b1;
                    hie     = 1'b1;
                    state_d = StRedirect;
                end else if (mc_start_i) begin
                    hpc     = 1'b1;
                    hif     = 1'b1;
                    hie     = 1'b1;
                    wd_d    = '0;
                    state_d = StMcWait;
                end else if (ld_hazard_i || ext_hold_i) begin
                    hpc = 1'b1;
                    hif = 1'b1;
                end
            end
        endcase
    end

    // Combinational outputs are forced low while reset is asserted
    assign hold_pc_o    = rst & hpc;
    assign hold_if_id_o = rst & hif;
    assign hold_id_ex_o = rst & hie;
    assign jump_flag_o  = rst & jmp;
    assign jump_addr_o  = (rst && jmp) ? {jump_addr_i[31:2], 2'b00} : 32'h0;
    assign misalign_o   = rst & jmp & (|jump_addr_i[1:0]);
    assign mc_timeout_o = rst & tmo;
    assign stall_cnt_o  = stall_q;
    assign state_o      = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            wd_q    <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (hold_pc_o && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; stimulus pushes expected outputs into a queue and a
// negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i, mc_start_i, mc_done_i, ld_hazard_i, ext_hold_i;
    logic [31:0] jump_addr_i;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, jump_flag_o, misalign_o, mc_timeout_o;
    logic [31:0] jump_addr_o;
    logic [3:0]  stall_cnt_o;
    logic [1:0]  state_o;

    pipe_ctrl #(
        .MC_TIMEOUT (8),
        .STALL_CNT_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .mc_start_i  (mc_start_i),
        .mc_done_i   (mc_done_i),
        .ld_hazard_i (ld_hazard_i),
        .ext_hold_i  (ext_hold_i),
        .hold_pc_o   (hold_pc_o),
        .hold_if_id_o(hold_if_id_o),
        .hold_id_ex_o(hold_id_ex_o),
        .jump_flag_o (jump_flag_o),
        .jump_addr_o (jump_addr_o),
        .misalign_o  (misalign_o),
        .mc_timeout_o(mc_timeout_o),
        .stall_cnt_o (stall_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hp;
        logic        hi;
        logic        he;
        logic        jf;
        logic [31:0] ja;
        logic        mis;
        logic        to;
        logic [1:0]  st;
        logic [3:0]  sc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;
    int    exp_stall = 0;

    // Monitor: outputs are settled mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            g = '{hold_pc_o, hold_if_id_o, hold_id_ex_o, jump_flag_o, jump_addr_o,
                  misalign_o, mc_timeout_o, state_o, stall_cnt_o};
            n_vec++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got hp=%b hi=%b he=%b jf=%b ja=%h mis=%b to=%b st=%0d sc=%0d, want hp=%b hi=%b he=%b jf=%b ja=%h mis=%b to=%b st=%0d sc=%0d",
                         nm, g.hp, g.hi, g.he, g.jf, g.ja, g.mis, g.to, g.st, g.sc,
                         e.hp, e.hi, e.he, e.jf, e.ja, e.mis, e.to, e.st, e.sc);
            end
        end
    end

    task automatic vec(input string nm, input logic r, input logic jf, input logic [31:0] ja,
                       input logic mcs, input logic mcd, input logic ld, input logic eh,
                       input logic ehp, input logic ehi, input logic ehe, input logic ejf,
                       input logic [31:0] eja, input logic emis, input logic eto,
                       input logic [1:0] est);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        jump_flag_i = jf;
        jump_addr_i = ja;
        mc_start_i  = mcs;
        mc_done_i   = mcd;
        ld_hazard_i = ld;
        ext_hold_i  = eh;
        if (!r) exp_stall = 0;
        e = '{ehp, ehi, ehe, ejf, eja, emis, eto, est, exp_stall[3:0]};
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (r && ehp && exp_stall < 15) exp_stall++;
    endtask

    // Running vector with no jump and no pulses expected
    task automatic vrun(input string nm, input logic mcs, input logic mcd, input logic ld,
                        input logic eh, input logic ehp, input logic ehi, input logic ehe,
                        input logic [1:0] est);
        vec(nm, 1'b1, 1'b0, 32'h0, mcs, mcd, ld, eh, ehp, ehi, ehe, 1'b0, 32'h0, 1'b0, 1'b0, est);
    endtask

    initial begin
        rst = 1'b0;
        jump_flag_i = 1'b0;
        jump_addr_i = 32'h0;
        mc_start_i = 1'b0;
        mc_done_i = 1'b0;
        ld_hazard_i = 1'b0;
        ext_hold_i = 1'b0;

        // Reset ignores inputs
        vec("rst_inputs", 1'b0, 1'b1, 32'h0000_0107, 1'b1, 1'b1, 1'b1, 1'b1,
            0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
        vec("rst_idle", 1'b0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
        vrun("post_rst", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Plain jump
        vec("jump", 1'b1, 1'b1, 32'h0000_0104, 0, 0, 0, 0,
            0, 1, 1, 1, 32'h0000_0104, 0, 0, 2'd0);
        vrun("redirect", 0, 0, 0, 0, 0, 1, 0, 2'd2);
        vrun("after_jump", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Multi-cycle op, done 5 cycles after start
        vrun("mc_start", 1, 0, 0, 0, 1, 1, 1, 2'd0);
        for (int i = 0; i < 4; i++) vrun("mc_wait", 0, 0, i[0], i[1], 1, 1, 1, 2'd1);
        vrun("mc_done", 0, 1, 0, 0, 0, 0, 0, 2'd1);
        vrun("after_done", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Jump beats mc_start and ld_hazard
        vec("prio_jump", 1'b1, 1'b1, 32'h0000_0104, 1, 0, 1, 0,
            0, 1, 1, 1, 32'h0000_0104, 0, 0, 2'd0);
        vrun("prio_redir", 0, 0, 0, 0, 0, 1, 0, 2'd2);
        vec("misalign", 1'b1, 1'b1, 32'h0000_0106, 0, 0, 0, 0,
            0, 1, 1, 1, 32'h0000_0104, 1, 0, 2'd0);
        vec("redir_ignore", 1'b1, 1'b1, 32'h0000_0203, 1, 0, 1, 1,
            1, 1, 0, 0, 32'h0, 0, 0, 2'd2);
        vrun("after_redir", 0, 0, 0, 0, 0, 0, 0, 2'd0);
        vec("misalign3", 1'b1, 1'b1, 32'hdead_beef, 0, 0, 0, 0,
            0, 1, 1, 1, 32'hdead_beec, 1, 0, 2'd0);
        vrun("redir2", 0, 0, 0, 0, 0, 1, 0, 2'd2);

        // Watchdog timeout in the 8th MC_WAIT cycle
        vrun("to_start", 1, 0, 0, 0, 1, 1, 1, 2'd0);
        for (int i = 0; i < 7; i++) vrun("to_wait", 0, 0, 0, 0, 1, 1, 1, 2'd1);
        vec("timeout", 1'b1, 0, 32'h0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 1, 2'd1);
        vrun("after_to", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Done in the 8th cycle wins over timeout
        vrun("td_start", 1, 0, 0, 0, 1, 1, 1, 2'd0);
        for (int i = 0; i < 7; i++) vrun("td_wait", 0, 0, 0, 0, 1, 1, 1, 2'd1);
        vrun("td_done", 0, 1, 0, 0, 0, 0, 0, 2'd1);
        vrun("after_td", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Reset mid-MC_WAIT aborts at once
        vrun("ra_start", 1, 0, 0, 0, 1, 1, 1, 2'd0);
        vrun("ra_wait", 0, 0, 0, 0, 1, 1, 1, 2'd1);
        vec("ra_reset", 1'b0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
        vrun("ra_release", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Single-cycle load-use hold
        vrun("ld_hazard", 0, 0, 1, 0, 1, 1, 0, 2'd0);
        vrun("after_ld", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Bus hold long enough to saturate the 4-bit counter
        for (int i = 0; i < 20; i++) vrun("ext_hold", 0, 0, 0, 1, 1, 1, 0, 2'd0);
        vrun("sat_check", 0, 0, 0, 0, 0, 0, 0, 2'd0);

        @(posedge clk);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the PC register, the IF/ID register and the ID/EX register.
- Arbitrates four stall/redirect sources into per-stage hold flags and a PC redirect:
  - branch/jump from EX
  - multi-cycle operation from EX
  - load-use hazard from ID
  - external bus hold
- Tracks multi-cycle operations with a watchdog.
- Counts stall cycles for performance monitoring.

Parameters:
MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced abort (must be >= 2)
STALL_CNT_W, 32, width of stall cycle counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
jump_flag_i  input  1  EX requests PC redirect this cycle
jump_addr_i  input  32  redirect target from EX
mc_start_i  input  1  EX issues multi-cycle op (1-cycle pulse)
mc_done_i  input  1  multi-cycle op result valid (1-cycle pulse)
ld_hazard_i  input  1  ID detects load-use dependency
ext_hold_i  input  1  bus/memory not ready, level
hold_pc_o  output  1  PC keeps current value
hold_if_id_o  output  1  IF/ID loads NOP instruction / zero address
hold_id_ex_o  output  1  ID/EX loads NOP bubble
jump_flag_o  output  1  PC loads jump_addr_o
jump_addr_o  output  32  redirect target, bits [1:0] forced 0
misalign_o  output  1  1-cycle pulse: jump_addr_i[1:0] != 0 on an accepted jump
mc_timeout_o  output  1  1-cycle pulse: watchdog abort
stall_cnt_o  output  STALL_CNT_W  cycles with hold_pc_o=1, saturating
state_o  output  2  FSM state: 0 RUN, 1 MC_WAIT, 2 REDIRECT

Behaviour:
- Reset (rst=0, async): state=RUN, watchdog counter=0, stall_cnt_o=0.
  - All other outputs are combinational and read 0 while in reset (inputs ignored).
  - Reset during MC_WAIT or REDIRECT aborts immediately; no pulse outputs are generated.
- Outputs are combinational from the registered state plus the current inputs, so a redirect takes effect in the same cycle jump_flag_i is sampled.
- jump_addr_o = {jump_addr_i[31:2],2'b00} whenever jump_flag_o=1; otherwise 0.
- RUN, priority jump > mc_start > ld_hazard > ext_hold:
  - jump_flag_i=1: jump_flag_o=1, hold_if_id_o=1, hold_id_ex_o=1, hold_pc_o=0. Next state REDIRECT.
  - mc_start_i=1 (no jump): hold_pc_o=1, hold_if_id_o=1, hold_id_ex_o=1. Watchdog cleared. Next state MC_WAIT.
  - ld_hazard_i=1: hold_pc_o=1, hold_if_id_o=1 for this cycle only. Stay RUN.
  - ext_hold_i=1: hold_pc_o=1, hold_if_id_o=1 while it stays high. Stay RUN.
  - None of the above: all holds 0.
- REDIRECT: exactly 1 cycle; squashes the stale ROM word (ROM read is registered).
  - hold_if_id_o=1; hold_pc_o=0; hold_id_ex_o=0.
  - jump_flag_i, mc_start_i and ld_hazard_i are ignored (ID/EX holds a bubble).
  - If ext_hold_i=1, hold_pc_o=1 as well.
  - Next state always RUN.
- MC_WAIT:
  - hold_pc_o=hold_if_id_o=hold_id_ex_o=1. ext_hold_i, ld_hazard_i and mc_start_i are ignored.
  - Watchdog increments every cycle.
  - mc_done_i=1: all holds 0 this cycle. jump_flag_i is evaluated as in RUN; a jump goes to REDIRECT, otherwise the next state is RUN.
  - No mc_done_i and watchdog == MC_TIMEOUT-1: mc_timeout_o=1, holds stay 1 this cycle, next state RUN.
  - mc_done_i in the timeout cycle: treated as done, no timeout pulse.
- Watchdog: $clog2(MC_TIMEOUT) bits.
  - Cleared on entry to MC_WAIT.
  - The MC_WAIT cycle in which the watchdog reads k is the (k+1)-th MC_WAIT cycle.
- misalign_o is asserted in the same cycle as jump_flag_o when jump_addr_i[1:0] != 0.
- stall_cnt_o: +1 on each clock edge where hold_pc_o=1; holds at 2^STALL_CNT_W-1 (no wrap).
- Unused state encoding 3: treated as RUN, with next state RUN.

Test Plan:
- Reset with rst=0 then release → all outputs 0, state_o=0. Assert rst=0 mid-MC_WAIT → state_o=0 immediately, stall_cnt_o=0.
- RUN, jump_flag_i=1, jump_addr_i=0x0000_0104 for 1 cycle → that cycle: jump_flag_o=1, jump_addr_o=0x104, hold_if_id_o=hold_id_ex_o=1. Next cycle: state_o=2, hold_if_id_o=1 only. Then RUN with no holds.
- mc_start_i pulse, mc_done_i 5 cycles later → hold_pc/if_id/id_ex high for 5 cycles, 0 in the done cycle, stall_cnt_o=5.
- Same cycle: jump_flag_i=1, mc_start_i=1, ld_hazard_i=1 → jump wins, state_o=2, no MC_WAIT entry. Then jump_addr_i=0x0000_0106 → jump_addr_o=0x104, misalign_o=1.
- MC_TIMEOUT=8, mc_start_i with no mc_done_i → mc_timeout_o pulses in the 8th MC_WAIT cycle, then RUN. Repeat with mc_done_i in the 8th cycle → no pulse.
- STALL_CNT_W=4, ext_hold_i held for 20 cycles → stall_cnt_o saturates at 15. Pulse ld_hazard_i once → holds for exactly 1 cycle.
